// File: rtl/ones_pattern_tx_pkg.sv
// Shared types and default sizing for the ones-pattern transmitter.
package ones_pattern_tx_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CW    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/ones_pattern_tx_therm_enc.sv
// Count-to-thermometer encoder: bit gi is set when the count exceeds gi,
// which also saturates counts larger than WIDTH to all ones.
module therm_enc
  import ones_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic [CW-1:0]    i_count,
  output logic [WIDTH-1:0] o_pattern
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_pattern[gi] = (i_count > CW'(gi));
    end
  endgenerate

endmodule

// File: rtl/ones_pattern_tx.sv
// Accepts a ones count, publishes the thermometer word and streams it out
// LSB first, one frame of WIDTH bits followed by one idle cycle.
module ones_pattern_tx
  import ones_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CW-1:0]    in_count,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             word_valid,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             err
);

  localparam logic [CW-1:0] LAST_IDX  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_pattern;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    w_idx_next;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_idx;
  logic             r_word_valid;
  logic             r_err;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_ser_last;

  therm_enc #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_therm_enc (
    .i_count   (in_count),
    .o_pattern (w_pattern)
  );

  assign w_shift_next = r_shift >> 1;
  assign w_idx_next   = r_idx + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        // The edge after the final bit is shown returns to IDLE, giving the idle gap.
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
      r_ser_out    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_ser_last   <= 1'b0;
    end else begin
      r_word_valid <= w_accept;
      r_err        <= w_accept && (in_count > MAX_COUNT);
      if (w_accept) begin
        r_word      <= w_pattern;
        r_shift     <= w_pattern;
        r_idx       <= '0;
        r_ser_out   <= w_pattern[0];
        r_ser_valid <= 1'b1;
        r_ser_last  <= (LAST_IDX == '0);
      end else if (r_state == SHIFT) begin
        if (w_last) begin
          r_idx       <= '0;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_ser_last  <= 1'b0;
        end else begin
          r_shift    <= w_shift_next;
          r_idx      <= w_idx_next;
          r_ser_out  <= w_shift_next[0];
          r_ser_last <= (w_idx_next == LAST_IDX);
        end
      end
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_word   = r_word;
  assign word_valid = r_word_valid;
  assign err        = r_err;
  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign ser_last   = r_ser_last;

endmodule

// File: tb/tb_ones_pattern_tx.sv
// Bench for ones_pattern_tx: directed frames, back-to-back, reset abort and
// randomized counts against an arithmetic model of the pattern.
module tb_ones_pattern_tx;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [CW-1:0]    in_count;
  logic             in_ready;
  logic [WIDTH-1:0] out_word;
  logic             word_valid;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             err;

  int               n_checks;
  int               n_errors;
  logic [WIDTH-1:0] last_word;
  logic [WIDTH-1:0] last_ser;

  ones_pattern_tx #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .in_ready   (in_ready),
    .out_word   (out_word),
    .word_valid (word_valid),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: n = min(count, WIDTH) ones in the low bits.
  function automatic int clamp_n(input int c);
    return (c > WIDTH) ? WIDTH : c;
  endfunction

  function automatic logic [WIDTH-1:0] model_word(input int c);
    int n;
    n = clamp_n(c);
    return WIDTH'((1 << n) - 1);
  endfunction

  // Starts at the sample just after the accept edge; ends at the idle sample.
  task automatic check_frame(input string tag, input logic [WIDTH-1:0] exp_word, input bit exp_err);
    for (int k = 0; k < WIDTH; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s.ser_valid[%0d]", tag, k), ser_valid, 1);
      check($sformatf("%s.ser_out[%0d]", tag, k), ser_out, exp_word[k]);
      check($sformatf("%s.ser_last[%0d]", tag, k), ser_last, (k == WIDTH - 1));
      check($sformatf("%s.in_ready[%0d]", tag, k), in_ready, 0);
      check($sformatf("%s.out_word[%0d]", tag, k), out_word, exp_word);
      check($sformatf("%s.word_valid[%0d]", tag, k), word_valid, (k == 0));
      check($sformatf("%s.err[%0d]", tag, k), err, (k == 0) && exp_err);
      last_ser[k] = ser_out;
    end
    last_word = out_word;
    @(posedge clk); #1;
    check($sformatf("%s.idle_ser_valid", tag), ser_valid, 0);
    check($sformatf("%s.idle_ser_last", tag), ser_last, 0);
    check($sformatf("%s.idle_ser_out", tag), ser_out, 0);
    check($sformatf("%s.idle_in_ready", tag), in_ready, 1);
    check($sformatf("%s.idle_word_valid", tag), word_valid, 0);
    check($sformatf("%s.idle_err", tag), err, 0);
    check($sformatf("%s.hold_word", tag), out_word, exp_word);
    check($sformatf("%s.stream_vs_word", tag), last_ser, last_word);
  endtask

  task automatic run_frame(input string tag, input int cnt);
    check($sformatf("%s.ready_pre", tag), in_ready, 1);
    in_count = CW'(cnt);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_frame(tag, model_word(cnt), cnt > WIDTH);
    check($sformatf("%s.popcount", tag), $countones(last_word), clamp_n(cnt));
    $display("frame %s count=%0d word=%b serial=%b", tag, cnt, last_word, last_ser);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_word", out_word, 0);
    check("rst.word_valid", word_valid, 0);
    check("rst.ser_valid", ser_valid, 0);
    check("rst.ser_out", ser_out, 0);
    check("rst.ser_last", ser_last, 0);
    check("rst.err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle.ser_valid", ser_valid, 0);

    run_frame("cnt3", 3);
    run_frame("cnt0", 0);
    run_frame("cnt6", 6);
    run_frame("cnt4", 4);

    // in_valid held through the first frame; second request waits for IDLE.
    in_count = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_count = 3'd4;
    check_frame("b2b_a", 4'b0011, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_frame("b2b_b", 4'b1111, 1'b0);
    $display("frame b2b counts=2,4 done");

    // Reset during the second serial bit, with in_valid asserted.
    in_count = 3'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort.bit0", ser_out, 1);
    @(posedge clk); #1;
    check("abort.bit1_valid", ser_valid, 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("abort.ser_valid", ser_valid, 0);
    check("abort.ser_last", ser_last, 0);
    check("abort.out_word", out_word, 0);
    check("abort.in_ready", in_ready, 1);
    check("abort.word_valid", word_valid, 0);
    check("abort.err", err, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort.post_ser_valid", ser_valid, 0);
    check("abort.post_ser_last", ser_last, 0);
    check("abort.post_word_valid", word_valid, 0);
    $display("frame abort done");

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_frame($sformatf("rnd%0d", i), int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
